// File: rtl/cpu_trace_pkg.sv
// Shared state encoding and entry-width helper for the CPU pipeline trace buffer.
// Entry layout, MSB first: {timestamp, stall, push, data}.
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } trace_state_t;

    localparam int unsigned FLAG_W = 2;

    function automatic int unsigned entry_w(int unsigned data_w, int unsigned ts_w);
        return ts_w + FLAG_W + data_w;
    endfunction

endpackage

// File: rtl/cpu_trace_ram.sv
// DEPTH x WIDTH simple dual-port trace RAM: one write port and a registered read
// port with 1-cycle latency. Only the read register is reset.
module cpu_trace_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 53
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data holds its last value between pops.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cpu_trace_buf.sv
// Pipeline trace recorder: timestamped stall-transition / stack-push capture into a
// circular RAM with arm/trigger control and pop readout. Define CPU_TRACE_DISPLAY_EN for sim logging.
module cpu_trace_buf
    import cpu_trace_pkg::*;
#(
    parameter int unsigned DATA_W    = 35,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned TS_W      = 16,
    parameter int unsigned POST_TRIG = 8
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     stall_2a,
    input  logic                     st__push_5a,
    input  logic [DATA_W-1:0]        st__to_push_5a,
    input  logic                     arm,
    input  logic                     trig,
    input  logic                     mode_wrap,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [TS_W+2+DATA_W-1:0] rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               state,
    output logic                     overflow,
    output logic [TS_W-1:0]          stall_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = entry_w(DATA_W, TS_W);

    trace_state_t   st;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  post_cnt;
    logic [TS_W-1:0] ts;
    logic           stall_q;
    logic           wrap_q;

    logic           recording;
    logic           cap_evt;
    logic           full;
    logic           wr_en;
    logic           pop;
    logic [EW-1:0]  entry;

    // arm dominates: nothing is captured or popped in the cycle the buffer is cleared.
    assign recording = (st == ARMED) || (st == POST);
    assign cap_evt   = recording && !arm && (st__push_5a || (stall_2a != stall_q));
    assign full      = (count == CW'(DEPTH));
    assign wr_en     = cap_evt && (!full || wrap_q);
    assign pop       = (st == DONE) && rd_en && !arm && (count != '0);
    assign entry     = {ts, stall_2a, st__push_5a, st__to_push_5a};
    assign state     = st;

    cpu_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk   (clk),
        .rst_b (rst_b),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (entry),
        .re    (pop),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            st        <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            ts        <= '0;
            stall_q   <= 1'b0;
            wrap_q    <= 1'b0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            ts       <= ts + TS_W'(1);
            stall_q  <= stall_2a;
            rd_valid <= pop;

            if (arm) begin
                st        <= ARMED;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                post_cnt  <= '0;
                overflow  <= 1'b0;
                stall_cnt <= '0;
                wrap_q    <= mode_wrap;
            end else begin
                if (recording && stall_2a && (stall_cnt != '1)) begin
                    stall_cnt <= stall_cnt + TS_W'(1);
                end

                // A write into a full wrapping buffer retires the oldest entry instead of growing.
                if (wr_en) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    if (full) begin
                        rd_ptr   <= rd_ptr + AW'(1);
                        overflow <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end

                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    count  <= count - CW'(1);
                end

                unique case (st)
                    IDLE: ;
                    ARMED: begin
                        if (cap_evt && full && !wrap_q) begin
                            st <= DONE;
                        end else if (trig) begin
                            if (POST_TRIG == 0) begin
                                st <= DONE;
                            end else begin
                                st       <= POST;
                                post_cnt <= CW'(POST_TRIG);
                            end
                        end
                    end
                    POST: begin
                        if (cap_evt && full && !wrap_q) begin
                            st <= DONE;
                        end else if (cap_evt) begin
                            post_cnt <= post_cnt - CW'(1);
                            if (post_cnt == CW'(1)) begin
                                st <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (pop && (count == CW'(1))) begin
                            st <= IDLE;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

`ifdef CPU_TRACE_DISPLAY_EN
    trace_state_t st_seen;

    always_ff @(posedge clk) begin
        st_seen <= st;
        if (st_seen != st) begin
            $display("[%0t] ==== cpu_trace_buf state %s -> %s ====", $time, st_seen.name(), st.name());
        end
        if (wr_en) begin
            $display("[%0t] trace capture ts=%0d stall=%b push=%b data=%h",
                     $time, ts, stall_2a, st__push_5a, st__to_push_5a);
        end
        if (rd_valid) begin
            $display("[%0t] trace pop ts=%0d stall=%b push=%b data=%h", $time,
                     rd_data[EW-1 -: TS_W], rd_data[DATA_W+1], rd_data[DATA_W], rd_data[DATA_W-1:0]);
        end
    end
`endif

endmodule

// File: tb/tb_cpu_trace_buf.sv
// Bench for cpu_trace_buf: two instances (POST_TRIG=0 and POST_TRIG=8) share stimulus and are
// checked every cycle against a queue-based reference model, plus directed literal checks.
module tb_cpu_trace_buf;

    localparam int DATA_W = 35;
    localparam int DEPTH  = 64;
    localparam int TS_W   = 16;
    localparam int EW     = TS_W + 2 + DATA_W;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int SC_MAX = (1 << TS_W) - 1;
    localparam int S_IDLE = 0, S_ARMED = 1, S_POST = 2, S_DONE = 3;

    logic              clk = 1'b0;
    logic              rst_b = 1'b1;
    logic              stall = 1'b0;
    logic              push = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              arm = 1'b0;
    logic              trig = 1'b0;
    logic              mode_wrap = 1'b0;
    logic              rd_en = 1'b0;

    logic              rdv0, rdv1, ovf0, ovf1;
    logic [EW-1:0]     rdd0, rdd1;
    logic [CW-1:0]     cnt0, cnt1;
    logic [1:0]        st0, st1;
    logic [TS_W-1:0]   sc0, sc1;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    cpu_trace_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W), .POST_TRIG(0)) u_pt0 (
        .clk(clk), .rst_b(rst_b), .stall_2a(stall), .st__push_5a(push), .st__to_push_5a(data),
        .arm(arm), .trig(trig), .mode_wrap(mode_wrap), .rd_en(rd_en), .rd_valid(rdv0),
        .rd_data(rdd0), .count(cnt0), .state(st0), .overflow(ovf0), .stall_cnt(sc0));

    cpu_trace_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W), .POST_TRIG(8)) u_pt8 (
        .clk(clk), .rst_b(rst_b), .stall_2a(stall), .st__push_5a(push), .st__to_push_5a(data),
        .arm(arm), .trig(trig), .mode_wrap(mode_wrap), .rd_en(rd_en), .rd_valid(rdv1),
        .rd_data(rdd1), .count(cnt1), .state(st1), .overflow(ovf1), .stall_cnt(sc1));

    // Reference model: one FIFO queue of entries per lane.
    logic [EW-1:0] q0[$];
    logic [EW-1:0] q1[$];
    int            m_state[2];
    int            m_post[2];
    int            m_scnt[2];
    bit            m_ovf[2];
    bit            m_wrap[2];
    bit            m_rdv[2];
    logic [EW-1:0] m_rdd[2];
    int            m_ts;
    bit            m_sq;

    function automatic int pt(int k);
        return (k == 0) ? 0 : 8;
    endfunction

    function automatic int qsize(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void pushq(int k, logic [EW-1:0] e);
        if (k == 0) q0.push_back(e); else q1.push_back(e);
    endfunction

    function automatic logic [EW-1:0] popq(int k);
        if (k == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void clearq(int k);
        if (k == 0) q0.delete(); else q1.delete();
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            clearq(k);
            m_state[k] = S_IDLE;
            m_post[k]  = 0;
            m_scnt[k]  = 0;
            m_ovf[k]   = 0;
            m_wrap[k]  = 0;
            m_rdv[k]   = 0;
            m_rdd[k]   = '0;
        end
        m_ts = 0;
        m_sq = 0;
    endtask

    task automatic model_step();
        logic [EW-1:0] e;
        e = {m_ts[TS_W-1:0], stall, push, data};
        for (int k = 0; k < 2; k++) begin
            int nxt;
            bit rec;
            bit cap;
            m_rdv[k] = 0;
            if (arm) begin
                clearq(k);
                m_ovf[k]   = 0;
                m_scnt[k]  = 0;
                m_post[k]  = 0;
                m_wrap[k]  = mode_wrap;
                m_state[k] = S_ARMED;
            end else begin
                rec = (m_state[k] == S_ARMED) || (m_state[k] == S_POST);
                if (rec && stall && m_scnt[k] < SC_MAX) m_scnt[k]++;
                cap = rec && (push || (stall != m_sq));
                nxt = m_state[k];
                if (cap && qsize(k) == DEPTH && !m_wrap[k]) begin
                    nxt = S_DONE;
                end else begin
                    if (cap) begin
                        if (qsize(k) == DEPTH) begin
                            void'(popq(k));
                            m_ovf[k] = 1;
                        end
                        pushq(k, e);
                    end
                    if (m_state[k] == S_ARMED && trig) begin
                        if (pt(k) == 0) nxt = S_DONE;
                        else begin
                            nxt = S_POST;
                            m_post[k] = pt(k);
                        end
                    end else if (m_state[k] == S_POST && cap) begin
                        m_post[k]--;
                        if (m_post[k] == 0) nxt = S_DONE;
                    end
                end
                if (m_state[k] == S_DONE && rd_en && qsize(k) > 0) begin
                    m_rdd[k] = popq(k);
                    m_rdv[k] = 1;
                    if (qsize(k) == 0) nxt = S_IDLE;
                end
                m_state[k] = nxt;
            end
        end
        m_ts = (m_ts + 1) % (1 << TS_W);
        m_sq = stall;
    endtask

    task automatic chk(string name, int k, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s lane%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            logic [1:0]      a_st;
            logic [CW-1:0]   a_cnt;
            logic            a_ovf;
            logic            a_rdv;
            logic [TS_W-1:0] a_sc;
            logic [EW-1:0]   a_rdd;
            if (k == 0) begin
                a_st = st0; a_cnt = cnt0; a_ovf = ovf0; a_rdv = rdv0; a_sc = sc0; a_rdd = rdd0;
            end else begin
                a_st = st1; a_cnt = cnt1; a_ovf = ovf1; a_rdv = rdv1; a_sc = sc1; a_rdd = rdd1;
            end
            chk("state", k, 64'(a_st), 64'(m_state[k]));
            chk("count", k, 64'(a_cnt), 64'(qsize(k)));
            chk("overflow", k, 64'(a_ovf), 64'(m_ovf[k]));
            chk("stall_cnt", k, 64'(a_sc), 64'(m_scnt[k]));
            chk("rd_valid", k, 64'(a_rdv), 64'(m_rdv[k]));
            if (m_rdv[k]) chk("rd_data", k, 64'(a_rdd), 64'(m_rdd[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_b) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_arm(bit wrap);
        mode_wrap = wrap;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        logic [TS_W-1:0] prev_ts;
        model_reset();
        #2 rst_b = 1'b0;
        tick();
        tick();
        chk("reset_rd_data", 0, 64'(rdd0), 64'd0);
        chk("reset_rd_data", 1, 64'(rdd1), 64'd0);
        chk("reset_state", 1, 64'(st1), 64'd0);
        rst_b = 1'b1;
        tick();

        // Three pushes, trigger, pop them back.
        do_arm(1'b0);
        for (int i = 1; i <= 3; i++) begin
            push = 1'b1; data = DATA_W'(i);
            tick();
        end
        push = 1'b0;
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("t1_state_done", 0, 64'(st0), 64'd3);
        chk("t1_count", 0, 64'(cnt0), 64'd3);
        chk("t1_pt8_post", 1, 64'(st1), 64'd2);
        prev_ts = '0;
        for (int i = 1; i <= 3; i++) begin
            rd_en = 1'b1;
            tick();
            chk("t1_pop_valid", 0, 64'(rdv0), 64'd1);
            chk("t1_pop_data", 0, 64'(rdd0[DATA_W-1:0]), 64'(i));
            if (i > 1) chk("t1_ts_increasing", 0, 64'(rdd0[EW-1 -: TS_W] > prev_ts), 64'd1);
            prev_ts = rdd0[EW-1 -: TS_W];
        end
        rd_en = 1'b0;
        tick();
        chk("t1_state_idle", 0, 64'(st0), 64'd0);
        chk("t1_count_empty", 0, 64'(cnt0), 64'd0);

        // Stall pulse of 5 cycles: rise and fall entries only.
        do_arm(1'b0);
        stall = 1'b1;
        repeat (5) tick();
        stall = 1'b0;
        tick();
        tick();
        chk("t2_count", 0, 64'(cnt0), 64'd2);
        chk("t2_stall_cnt", 0, 64'(sc0), 64'd5);
        chk("t2_stall_cnt", 1, 64'(sc1), 64'd5);

        // Wrap mode, 70 pushes.
        do_arm(1'b1);
        for (int i = 0; i < 70; i++) begin
            push = 1'b1; data = DATA_W'(i);
            tick();
        end
        push = 1'b0;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("t3_overflow", 0, 64'(ovf0), 64'd1);
        chk("t3_count", 0, 64'(cnt0), 64'd64);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t3_first_pop", 0, 64'(rdd0[DATA_W-1:0]), 64'd6);

        // Stop-when-full mode, 70 pushes, full readback.
        do_arm(1'b0);
        for (int i = 0; i < 70; i++) begin
            push = 1'b1; data = DATA_W'(i);
            tick();
        end
        push = 1'b0;
        chk("t4_state_done", 0, 64'(st0), 64'd3);
        chk("t4_state_done", 1, 64'(st1), 64'd3);
        chk("t4_count", 1, 64'(cnt1), 64'd64);
        chk("t4_no_overflow", 0, 64'(ovf0), 64'd0);
        for (int i = 0; i < 64; i++) begin
            rd_en = 1'b1;
            tick();
            chk("t4_pop_data", 0, 64'(rdd0[DATA_W-1:0]), 64'(i));
            chk("t4_pop_data", 1, 64'(rdd1[DATA_W-1:0]), 64'(i));
        end
        rd_en = 1'b0;
        tick();
        chk("t4_state_idle", 1, 64'(st1), 64'd0);

        // Post-trigger window of 8 captures.
        do_arm(1'b0);
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; data = DATA_W'(i);
            tick();
        end
        trig = 1'b1; data = DATA_W'(100);
        tick();
        trig = 1'b0;
        for (int i = 0; i < 20; i++) begin
            data = DATA_W'(200 + i);
            tick();
        end
        push = 1'b0;
        chk("t5_count", 1, 64'(cnt1), 64'd14);
        chk("t5_state_done", 1, 64'(st1), 64'd3);
        chk("t5_count", 0, 64'(cnt0), 64'd6);

        // arm + trig + rd_en together in DONE.
        arm = 1'b1; trig = 1'b1; rd_en = 1'b1;
        tick();
        arm = 1'b0; trig = 1'b0; rd_en = 1'b0;
        chk("t6_state_armed", 0, 64'(st0), 64'd1);
        chk("t6_state_armed", 1, 64'(st1), 64'd1);
        chk("t6_count", 1, 64'(cnt1), 64'd0);
        chk("t6_rd_valid", 1, 64'(rdv1), 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            arm = ($urandom_range(0, 149) == 0);
            mode_wrap = $urandom_range(0, 1);
            trig = ($urandom_range(0, 15) == 0);
            rd_en = $urandom_range(0, 1);
            data = DATA_W'({$urandom(), $urandom()});
            if (arm) push = 1'b0;
            else begin
                push = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 7) == 0) stall = ~stall;
            end
            tick();
        end
        arm = 1'b0; trig = 1'b0; rd_en = 1'b0; push = 1'b0; stall = 1'b0;
        tick();

        // Reset asserted while the POST_TRIG=8 lane is in POST.
        do_arm(1'b0);
        stall = 1'b1; push = 1'b1; data = DATA_W'(7);
        tick();
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        push = 1'b0;
        chk("t7_pre_reset_post", 1, 64'(st1), 64'd2);
        rst_b = 1'b0;
        #1;
        model_reset();
        chk("t7_reset_state", 1, 64'(st1), 64'd0);
        chk("t7_reset_count", 1, 64'(cnt1), 64'd0);
        chk("t7_reset_rd_valid", 1, 64'(rdv1), 64'd0);
        chk("t7_reset_rd_data", 1, 64'(rdd1), 64'd0);
        chk("t7_reset_overflow", 1, 64'(ovf1), 64'd0);
        chk("t7_reset_stall_cnt", 1, 64'(sc1), 64'd0);
        compare_all();
        stall = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
